// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 8;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after rr_ptr_i wins.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [ID_W-1:0]    winner_id_o,
  output logic               any_req_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  // Scan ptr+1 .. ptr+NUM_REQ so the previous owner is checked last.
  always_comb begin
    winner_o    = '0;
    winner_id_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        winner_o[cand] = 1'b1;
        winner_id_o    = cand;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port with packet-aware hold and burst cap.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ   = DEF_NUM_REQ,
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  MAX_BURST = DEF_MAX_BURST,
  localparam int ID_W      = clog2_min1(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]   beat_cnt_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_id;
  logic               any_req;

  logic               own_valid;
  logic               own_last;
  logic               at_max;
  logic               release_burst;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (pick_onehot),
    .winner_id_o (pick_id),
    .any_req_o   (any_req)
  );

  // Owner data mux; grant_id_q is 0 when idle, so this idles on requester 0.
  always_comb begin
    fifo_din  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        fifo_din  = req_data[i*DATA_W +: DATA_W];
        own_valid = req_valid[i];
        own_last  = req_last[i];
      end
    end
  end

  assign req_ready     = grant_q & {NUM_REQ{~fifo_full}};
  assign fifo_wr_en    = busy_q & own_valid & ~fifo_full;
  assign beat_cnt_d    = beat_cnt_q + CNT_W'(1);
  assign at_max        = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_burst = fifo_wr_en & (own_last | at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= BURST;
            grant_q    <= pick_onehot;
            grant_id_q <= pick_id;
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        BURST: begin
          // Last beat and burst cap coinciding still yield one release.
          if (release_burst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= grant_id_q;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
          end else if (fifo_wr_en) begin
            beat_cnt_q <= beat_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter (4 requesters, 16-bit, burst cap 8).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_last = '0;
  logic [NR-1:0]  req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_din;
  logic [NR-1:0]  grant;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int n_wr        = 0;
  int last_wr_cyc = 0;
  int blen        = 0;
  int blog[$];

  logic [16:0] txq [NR][$];   // {last, data} per requester
  logic [17:0] expq[$];       // {id, data} in expected write order

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic bit pending();
    bit p;
    p = (expq.size() != 0) || busy;
    for (int i = 0; i < NR; i++) if (txq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic load(input int r, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) txq[r].push_back({(k == n - 1), 16'(base + k)});
  endtask

  task automatic expect_beats(input int r, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) expq.push_back({2'(r), 16'(base + k)});
  endtask

  task automatic wait_drain(input string nm, input int max_cyc);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (pending() && k < max_cyc) begin
      @(negedge clk); #1;
      k++;
    end
    chk({nm, "_drain"}, 32'(pending()), 0);
  endtask

  task automatic wait_busy(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_busy"}, 32'(busy), 1);
  endtask

  task automatic chk_blog(input string nm, input int n, input int l0, input int l1, input int l2);
    int want[3];
    want = '{l0, l1, l2};
    chk({nm, "_nbursts"}, blog.size(), n);
    for (int i = 0; i < n && i < blog.size(); i++) chk({nm, "_burst_len"}, blog[i], want[i]);
  endtask

  // Requester models: hold each beat until handshaken; reset cycles never accept.
  initial begin
    logic [NR-1:0] acc;
    logic [16:0]   e;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready & {NR{~rst}};
      @(posedge clk); #2;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (txq[i].size() > 0) begin
          e = txq[i][0];
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = e[15:0];
          req_last[i]           = e[16];
        end else begin
          req_valid[i]          = 1'b0;
          req_data[i*DW +: DW]  = '0;
          req_last[i]           = 1'b0;
        end
      end
    end
  end

  // Monitor: every FIFO write is matched against the head of the scoreboard.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en && !rst) begin
        n_wr++;
        last_wr_cyc = cyc;
        blen++;
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got id %0d data %h, none expected", grant_id, fifo_din);
        end else begin
          e = expq.pop_front();
          chk("wr_id", 32'(grant_id), 32'(e[17:16]));
          chk("wr_data", 32'(fifo_din), 32'(e[15:0]));
          chk("wr_grant", 32'(grant), 32'(4'b0001 << e[17:16]));
        end
      end
      if (!busy && blen != 0) begin
        blog.push_back(blen);
        blen = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int start;
    int k;

    // Reset with everyone requesting, then two rounds of 1-beat packets.
    for (int r = 0; r < NR; r++) load(r, 1, 16'(16'h00A0 + r));
    for (int r = 0; r < NR; r++) load(r, 1, 16'(16'h00B0 + r));
    for (int r = 0; r < NR; r++) expect_beats(r, 1, 16'(16'h00A0 + r));
    for (int r = 0; r < NR; r++) expect_beats(r, 1, 16'(16'h00B0 + r));
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rel_cyc = cyc;
    @(negedge clk);
    chk("bubble_grant", 32'(grant), 0);
    @(negedge clk);
    chk("first_grant", 32'(grant), 1);
    chk("first_wr_en", 32'(fifo_wr_en), 1);
    wait_drain("rr", 40);
    chk("rr_span", 32'(last_wr_cyc - rel_cyc), 15);

    // 20-beat packet split at the burst cap.
    blog.delete();
    load(2, 20, 16'h0201);
    expect_beats(2, 20, 16'h0201);
    wait_drain("split", 60);
    chk_blog("split", 3, 8, 8, 4);

    // Backpressure on burst cycles 3..6.
    blog.delete();
    load(1, 10, 16'h0001);
    expect_beats(1, 10, 16'h0001);
    wait_busy("bp");
    @(posedge clk); #1;
    @(posedge clk); #1;
    fifo_full = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_wr_en", 32'(fifo_wr_en), 0);
      chk("bp_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    wait_drain("bp", 40);
    chk_blog("bp", 2, 8, 2, 0);

    // Last beat coincides with the cap: one release, requester 3 goes next.
    blog.delete();
    load(0, 8, 16'h0301);
    load(0, 1, 16'h03F0);
    expect_beats(0, 8, 16'h0301);
    expect_beats(3, 1, 16'h0330);
    expect_beats(0, 1, 16'h03F0);
    wait_busy("cap");
    load(3, 1, 16'h0330);
    wait_drain("cap", 40);
    chk_blog("cap", 3, 8, 1, 1);

    // Reset after three accepted beats of requester 1.
    load(1, 6, 16'h0101);
    expect_beats(1, 3, 16'h0101);
    start = n_wr;
    k = 0;
    @(negedge clk); #1;
    while (n_wr < start + 3 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    chk("mid_beats", 32'(n_wr - start), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    load(0, 1, 16'h00C0);
    expect_beats(0, 1, 16'h00C0);
    expect_beats(1, 3, 16'h0104);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_wr_en", 32'(fifo_wr_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain("post_rst", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
